piso_frame_tx: RTL and testbench

- Parallel-in, serial-out framed transmitter in the sequential-circuits library.
- Accepts a WIDTH-bit word through a valid/ready handshake and stores it internally.
- Emits the word on a single-wire output framed as start bit (0), WIDTH data bits, stop bit (1). Each bit is held for CLKS_PER_BIT clocks.
- Provides the send side for single-wire capture/storage blocks; its output feeds a matching serial receiver.

---
 rtl/piso_frame_tx_if.sv | 21 ++
 rtl/piso_frame_tx.sv | 109 ++++++++++
 tb/tb_piso_frame_tx.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/piso_frame_tx_if.sv
// Word handshake between a producer and the piso_frame_tx serializer.
// The producer drives din/din_valid; the transmitter answers with din_ready.
interface piso_frame_tx_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;

    modport master (
        output din,
        output din_valid,
        input  din_ready
    );

    modport slave (
        input  din,
        input  din_valid,
        output din_ready
    );
endinterface

// File: rtl/piso_frame_tx.sv
// Framed parallel-to-serial transmitter: start bit (0), WIDTH data bits, stop bit (1),
// each held for CLKS_PER_BIT clocks. tx/busy/done are registered.
module piso_frame_tx #(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter bit          LSB_FIRST    = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    piso_frame_tx_if.slave   bus,
    output logic             tx,
    output logic             busy,
    output logic             done
);
    localparam int unsigned PerW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned BitW = $clog2(WIDTH + 1);
    localparam logic [PerW-1:0] PerLast = PerW'(CLKS_PER_BIT - 1);
    localparam logic [BitW-1:0] BitLast = BitW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  shreg_q, shreg_d;
    logic [BitW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [PerW-1:0]   per_cnt_q, per_cnt_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              ready;
    logic              accept;
    logic              per_end;

    assign ready         = (state_q == StIdle) && !rst;
    assign bus.din_ready = ready;
    assign accept        = bus.din_valid && ready;
    assign per_end       = (per_cnt_q == PerLast);

    assign tx   = tx_q;
    assign busy = busy_q;
    assign done = done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            per_cnt_q <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            per_cnt_q <= per_cnt_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // The period counter restarts at every bit boundary, which also covers every state change.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        per_cnt_d = per_end ? '0 : per_cnt_q + PerW'(1);
        unique case (state_q)
            StIdle: begin
                per_cnt_d = '0;
                bit_cnt_d = '0;
                if (accept) begin
                    shreg_d = bus.din;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (per_end) state_d = StData;
            end
            StData: begin
                if (per_end) begin
                    if (bit_cnt_q == BitLast) begin
                        state_d   = StStop;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BitW'(1);
                        shreg_d   = (LSB_FIRST != 1'b0) ? (shreg_q >> 1) : (shreg_q << 1);
                    end
                end
            end
            StStop: begin
                if (per_end) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are computed from the next state so that they land registered with it.
    always_comb begin
        tx_d   = 1'b1;
        busy_d = (state_d != StIdle);
        done_d = (state_q == StStop) && per_end;
        unique case (state_d)
            StStart: tx_d = 1'b0;
            StData:  tx_d = (LSB_FIRST != 1'b0) ? shreg_d[0] : shreg_d[WIDTH-1];
            default: tx_d = 1'b1;
        endcase
    end
endmodule

// File: tb/tb_piso_frame_tx.sv
// Directed bench for piso_frame_tx: three instances cover LSB-first, MSB-first and
// single-clock bit periods; every frame is checked cycle by cycle against slot patterns.
module tb_piso_frame_tx;
    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   sel;

    piso_frame_tx_if #(.WIDTH(8)) ifa ();
    piso_frame_tx_if #(.WIDTH(8)) ifm ();
    piso_frame_tx_if #(.WIDTH(8)) ifc ();

    logic tx_a, busy_a, done_a;
    logic tx_m, busy_m, done_m;
    logic tx_c, busy_c, done_c;
    logic tx_s, busy_s, done_s, rdy_s;

    piso_frame_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .LSB_FIRST(1'b1)) dut_a (
        .clk  (clk),
        .rst  (rst),
        .bus  (ifa),
        .tx   (tx_a),
        .busy (busy_a),
        .done (done_a)
    );

    piso_frame_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .LSB_FIRST(1'b0)) dut_m (
        .clk  (clk),
        .rst  (rst),
        .bus  (ifm),
        .tx   (tx_m),
        .busy (busy_m),
        .done (done_m)
    );

    piso_frame_tx #(.WIDTH(8), .CLKS_PER_BIT(1), .LSB_FIRST(1'b1)) dut_c (
        .clk  (clk),
        .rst  (rst),
        .bus  (ifc),
        .tx   (tx_c),
        .busy (busy_c),
        .done (done_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        case (sel)
            0: begin tx_s = tx_a; busy_s = busy_a; done_s = done_a; rdy_s = ifa.din_ready; end
            1: begin tx_s = tx_m; busy_s = busy_m; done_s = done_m; rdy_s = ifm.din_ready; end
            default: begin
                tx_s = tx_c; busy_s = busy_c; done_s = done_c; rdy_s = ifc.din_ready;
            end
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int s, input logic [7:0] d, input logic v);
        case (s)
            0: begin ifa.din = d; ifa.din_valid = v; end
            1: begin ifm.din = d; ifm.din_valid = v; end
            default: begin ifc.din = d; ifc.din_valid = v; end
        endcase
    endtask

    // Called at a falling edge. slots[k] is the tx level expected in data slot k.
    task automatic run_frame(input int s, input logic [7:0] word, input logic [7:0] slots,
                             input int c, input bit hold, input logic [7:0] next_word);
        int   last;
        int   slot;
        logic exp_tx;
        last = 10 * c + 1;
        sel  = s;
        #1;
        check($sformatf("ready_pre s%0d", s), 32'(rdy_s), 32'd1);
        drive(s, word, 1'b1);
        @(posedge clk);
        for (int n = 1; n <= last; n++) begin
            @(negedge clk);
            if (n == 1) drive(s, 8'hFF, hold);
            slot = (n - 1) / c;
            if (slot == 0)      exp_tx = 1'b0;
            else if (slot <= 8) exp_tx = slots[slot-1];
            else                exp_tx = 1'b1;
            check($sformatf("tx s%0d w%0h n%0d", s, word, n), 32'(tx_s), 32'(exp_tx));
            check($sformatf("busy s%0d w%0h n%0d", s, word, n), 32'(busy_s),
                  (n < last) ? 32'd1 : 32'd0);
            check($sformatf("done s%0d w%0h n%0d", s, word, n), 32'(done_s),
                  (n == last) ? 32'd1 : 32'd0);
            if (n == last) begin
                check($sformatf("ready_done s%0d w%0h", s, word), 32'(rdy_s), 32'd1);
                if (hold) drive(s, next_word, 1'b1);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        sel   = 0;
        rst   = 1'b1;
        drive(0, 8'h00, 1'b0);
        drive(1, 8'h00, 1'b0);
        drive(2, 8'h00, 1'b0);

        // Reset with valid asserted: nothing may start.
        drive(0, 8'hA5, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("rst tx %0d", i), 32'(tx_a), 32'd1);
            check($sformatf("rst busy %0d", i), 32'(busy_a), 32'd0);
            check($sformatf("rst done %0d", i), 32'(done_a), 32'd0);
            check($sformatf("rst ready %0d", i), 32'(ifa.din_ready), 32'd0);
        end
        rst = 1'b0;
        drive(0, 8'h00, 1'b0);
        @(negedge clk);
        check("post_rst busy", 32'(busy_a), 32'd0);
        check("post_rst tx", 32'(tx_a), 32'd1);

        // A5 LSB first: slots 1,0,1,0,0,1,0,1.
        run_frame(0, 8'hA5, 8'hA5, 4, 1'b0, 8'h00);
        // MSB first: A5 is a palindrome; 01 puts the only 1 in the last slot.
        run_frame(1, 8'hA5, 8'hA5, 4, 1'b0, 8'h00);
        run_frame(1, 8'h01, 8'h80, 4, 1'b0, 8'h00);

        // Back-to-back, valid held; din forced to FF mid-frame must not matter.
        run_frame(0, 8'h3C, 8'h3C, 4, 1'b1, 8'hC3);
        run_frame(0, 8'hC3, 8'hC3, 4, 1'b0, 8'h00);

        // Reset during data bit 3 (cycles 17..20) of 55.
        sel = 0;
        drive(0, 8'h55, 1'b1);
        @(posedge clk);
        @(negedge clk);
        drive(0, 8'hFF, 1'b0);
        repeat (17) @(negedge clk);
        check("mid tx bit3", 32'(tx_a), 32'd0);
        check("mid busy", 32'(busy_a), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst tx", 32'(tx_a), 32'd1);
        check("mid_rst busy", 32'(busy_a), 32'd0);
        check("mid_rst done", 32'(done_a), 32'd0);
        check("mid_rst ready", 32'(ifa.din_ready), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            check($sformatf("mid_idle done %0d", i), 32'(done_a), 32'd0);
            check($sformatf("mid_idle tx %0d", i), 32'(tx_a), 32'd1);
        end
        run_frame(0, 8'h0F, 8'h0F, 4, 1'b0, 8'h00);

        // One clock per bit: F0 -> 0,0,0,0,0,1,1,1,1,1; done at cycle 11.
        run_frame(2, 8'hF0, 8'hF0, 1, 1'b0, 8'h00);

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
